// File: rtl/ob_pkg.sv
// Shared types and constants for the limit order book: FSM states, side encoding,
// empty-side price sentinels and default field widths.
package ob_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSERT,
        ST_SCAN,
        ST_CHECK,
        ST_MATCH
    } ob_state_t;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    localparam logic [7:0] BID_EMPTY = 8'h00;
    localparam logic [7:0] ASK_EMPTY = 8'hFF;

    localparam int DEF_PRICE_W = 8;
    localparam int DEF_QTY_W   = 8;

    // Slot index width; a single-slot book still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/book_side.sv
// One side of the book: slot storage, first-free insert, one-slot-per-cycle best-price scan
// and decrement/free of the winning slot. best_price/best_idx move only when a scan completes.
module book_side
    import ob_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PRICE_W  = DEF_PRICE_W,
    parameter int QTY_W    = DEF_QTY_W,
    parameter int CNT_W    = $clog2(DEPTH + 1),
    parameter int IDX_W    = idx_width(DEPTH),
    parameter bit SEEK_MAX = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ins_en,
    input  logic [PRICE_W-1:0] ins_price,
    input  logic [QTY_W-1:0]   ins_qty,
    input  logic               scan_en,
    input  logic [IDX_W-1:0]   scan_idx,
    input  logic               dec_en,
    input  logic [QTY_W-1:0]   dec_qty,
    output logic               full,
    output logic [CNT_W-1:0]   count,
    output logic [PRICE_W-1:0] best_price,
    output logic [QTY_W-1:0]   best_qty
);

    localparam logic [PRICE_W-1:0] EMPTY = SEEK_MAX ? {PRICE_W{1'b0}} : {PRICE_W{1'b1}};

    logic [DEPTH-1:0]   slot_vld;
    logic [PRICE_W-1:0] slot_price [DEPTH];
    logic [QTY_W-1:0]   slot_qty   [DEPTH];

    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   best_idx;

    logic               run_found;
    logic [PRICE_W-1:0] run_price;
    logic [IDX_W-1:0]   run_idx;

    logic               prev_found;
    logic [PRICE_W-1:0] cur_price;
    logic               better;
    logic               take;
    logic               nxt_found;
    logic [PRICE_W-1:0] nxt_price;
    logic [IDX_W-1:0]   nxt_idx;
    logic               scan_last;
    logic               dec_frees;

    assign full      = (count == CNT_W'(DEPTH));
    assign best_qty  = slot_qty[best_idx];
    assign scan_last = (scan_idx == IDX_W'(DEPTH - 1));
    assign dec_frees = (slot_qty[best_idx] == dec_qty);

    // Descending walk so the last hit is the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!slot_vld[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Strict comparison keeps the earlier (lower) index on equal prices.
    always_comb begin
        cur_price  = slot_price[scan_idx];
        prev_found = (scan_idx == '0) ? 1'b0 : run_found;
        better     = SEEK_MAX ? (cur_price > run_price) : (cur_price < run_price);
        take       = slot_vld[scan_idx] && (!prev_found || better);
        nxt_found  = prev_found || take;
        nxt_price  = take ? cur_price : run_price;
        nxt_idx    = take ? scan_idx : run_idx;
    end

    always_ff @(posedge clk) begin
        if (ins_en) begin
            slot_price[free_idx] <= ins_price;
            slot_qty[free_idx]   <= ins_qty;
        end else if (dec_en) begin
            slot_qty[best_idx] <= slot_qty[best_idx] - dec_qty;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld   <= '0;
            count      <= '0;
            best_price <= EMPTY;
            best_idx   <= '0;
            run_found  <= 1'b0;
            run_price  <= '0;
            run_idx    <= '0;
        end else begin
            if (ins_en) begin
                slot_vld[free_idx] <= 1'b1;
                count              <= count + CNT_W'(1);
            end else if (dec_en && dec_frees) begin
                slot_vld[best_idx] <= 1'b0;
                count              <= count - CNT_W'(1);
            end
            if (scan_en) begin
                run_found <= nxt_found;
                run_price <= nxt_price;
                run_idx   <= nxt_idx;
                if (scan_last) begin
                    best_price <= nxt_found ? nxt_price : EMPTY;
                    best_idx   <= nxt_idx;
                end
            end
        end
    end

endmodule

// File: rtl/order_book.sv
// Limit order book: accept -> insert -> DEPTH-cycle scan -> cross check -> match, repeating until uncrossed.
// Best prices at T+DEPTH+2, match_signal at T+DEPTH+3; order_ready is low outside IDLE.
module order_book
    import ob_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PRICE_W = DEF_PRICE_W,
    parameter int QTY_W   = DEF_QTY_W,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               order_valid,
    output logic               order_ready,
    input  logic               order_side,
    input  logic [PRICE_W-1:0] order_price,
    input  logic [QTY_W-1:0]   order_qty,
    output logic               order_reject,
    output logic [PRICE_W-1:0] best_bid,
    output logic [PRICE_W-1:0] best_ask,
    output logic [CNT_W-1:0]   bid_count,
    output logic [CNT_W-1:0]   ask_count,
    output logic               match_signal,
    output logic [PRICE_W-1:0] match_price,
    output logic [QTY_W-1:0]   match_qty
);

    localparam int IDX_W = idx_width(DEPTH);

    ob_state_t          state, state_nxt;
    logic               ord_side;
    logic [PRICE_W-1:0] ord_price;
    logic [QTY_W-1:0]   ord_qty;
    logic [IDX_W-1:0]   scan_idx;

    logic               bid_full, ask_full;
    logic [QTY_W-1:0]   bid_qty, ask_qty, trade_qty;
    logic               bad_order, crossed;
    logic               ins_bid, ins_ask, scan_en, dec_en;

    assign bad_order = (ord_price == '0) || (ord_price == '1) || (ord_qty == '0) ||
                       ((ord_side == SIDE_BUY) ? bid_full : ask_full);
    assign crossed   = (bid_count != '0) && (ask_count != '0) && (best_bid >= best_ask);
    assign trade_qty = (bid_qty < ask_qty) ? bid_qty : ask_qty;

    assign order_ready  = (state == ST_IDLE);
    assign order_reject = (state == ST_INSERT) && bad_order;

    always_comb begin
        state_nxt = state;
        ins_bid   = 1'b0;
        ins_ask   = 1'b0;
        scan_en   = 1'b0;
        dec_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (order_valid) state_nxt = ST_INSERT;
            end
            ST_INSERT: begin
                if (bad_order) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ins_bid   = (ord_side == SIDE_BUY);
                    ins_ask   = (ord_side != SIDE_BUY);
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                scan_en = 1'b1;
                if (scan_idx == IDX_W'(DEPTH - 1)) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = crossed ? ST_MATCH : ST_IDLE;
            end
            ST_MATCH: begin
                dec_en    = 1'b1;
                state_nxt = ST_SCAN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ord_side     <= 1'b0;
            ord_price    <= '0;
            ord_qty      <= '0;
            scan_idx     <= '0;
            match_signal <= 1'b0;
            match_price  <= '0;
            match_qty    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && order_valid) begin
                ord_side  <= order_side;
                ord_price <= order_price;
                ord_qty   <= order_qty;
            end
            if (state == ST_SCAN) begin
                scan_idx <= scan_idx + IDX_W'(1);
            end else begin
                scan_idx <= '0;
            end
            // Trade terms are registered on entry to MATCH so they are stable for the decrement.
            match_signal <= (state == ST_CHECK) && crossed;
            if (state == ST_CHECK && crossed) begin
                match_price <= best_ask;
                match_qty   <= trade_qty;
            end
        end
    end

    book_side #(
        .DEPTH   (DEPTH),
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W),
        .SEEK_MAX(1'b1)
    ) u_bids (
        .clk       (clk),
        .reset_n   (reset_n),
        .ins_en    (ins_bid),
        .ins_price (ord_price),
        .ins_qty   (ord_qty),
        .scan_en   (scan_en),
        .scan_idx  (scan_idx),
        .dec_en    (dec_en),
        .dec_qty   (match_qty),
        .full      (bid_full),
        .count     (bid_count),
        .best_price(best_bid),
        .best_qty  (bid_qty)
    );

    book_side #(
        .DEPTH   (DEPTH),
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W),
        .SEEK_MAX(1'b0)
    ) u_asks (
        .clk       (clk),
        .reset_n   (reset_n),
        .ins_en    (ins_ask),
        .ins_price (ord_price),
        .ins_qty   (ord_qty),
        .scan_en   (scan_en),
        .scan_idx  (scan_idx),
        .dec_en    (dec_en),
        .dec_qty   (match_qty),
        .full      (ask_full),
        .count     (ask_count),
        .best_price(best_ask),
        .best_qty  (ask_qty)
    );

endmodule
